tetris_game_ctrl: RTL
=====================

Name: tetris_game_ctrl

Overview:
Central game sequencer for the Tetris core. Owns the authoritative game_current_state register and the 200-bit settled-board register, and gives board ownership to the active phase. It also runs the gravity timer during FALLING and performs row-by-row line clearing after a piece locks. Phase modules such as the initial/start-screen handler and the piece generator/mover feed it next-state and board proposals; it broadcasts the current state back to them.

Parameters:
DROP_DIV, 50_000_000, clk cycles per gravity step in normal fall
FAST_DIV, 5_000_000, clk cycles per gravity step while soft_drop is held
CNT_W, 26, width of the gravity counter; must hold DROP_DIV-1

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
rotate  input  1  level; start/restart button, shared with piece rotation
soft_drop  input  1  level; selects FAST_DIV while FALLING
game_next_state_initial  input  3  next-state proposal from the INITIAL-phase handler
blocks_exist_initial  input  200  board proposal from the INITIAL-phase handler
spawn_blocked  input  1  1-cycle pulse in GENERATE_PIECE: the new piece overlaps the board
spawn_done  input  1  1-cycle pulse in GENERATE_PIECE: the piece was placed successfully
piece_landed  input  1  1-cycle pulse in FALLING: the piece cannot move down
board_merged  input  200  settled board OR'd with the landed piece; valid together with piece_landed
game_current_state  output  3  registered game state
blocks_exist  output  200  registered settled board; bit = row*10+col, row 0 top, row 19 bottom
drop_tick  output  1  registered 1-cycle gravity pulse
lines_cleared  output  16  total lines cleared; saturates at 16'hFFFF
clearing  output  1  high while in CLEAR_LINES

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: game_current_state=INITIAL, blocks_exist=0, drop_tick=0, lines_cleared=0, clearing=0, gravity counter=0, row pointer=19.
- An rst_n assertion during any state, including in the middle of CLEAR_LINES, takes effect immediately. No partial row shift survives reset.
- State encodings, 3 bits: INITIAL=0, GENERATE_PIECE=1, FALLING=2, CLEAR_LINES=3, GAME_OVER=4. Codes 5-7 go to INITIAL on the next clock.
- INITIAL:
  - Each cycle, blocks_exist <= blocks_exist_initial and lines_cleared <= 0.
  - If game_next_state_initial==GENERATE_PIECE, go to GENERATE_PIECE. Any other value stays in INITIAL.
  - The handler's output is registered, so the transition happens 2 clocks after rotate is first sampled high.
- GENERATE_PIECE:
  - spawn_blocked goes to GAME_OVER.
  - Otherwise spawn_done goes to FALLING.
  - If both pulses arrive in the same cycle, spawn_blocked wins.
  - With neither pulse, stay.
- FALLING:
  - The gravity counter increments each clk.
  - When counter == div-1, drop_tick=1 for one cycle and the counter returns to 0. div is FAST_DIV when soft_drop=1, else DROP_DIV.
  - If soft_drop rises while counter >= FAST_DIV-1, the next clock fires drop_tick and clears the counter.
  - The counter is cleared on entry to FALLING and is frozen to 0 in every other state.
  - piece_landed loads blocks_exist <= board_merged, sets the row pointer to 19 and goes to CLEAR_LINES.
  - drop_tick is suppressed in the cycle piece_landed is seen.
- CLEAR_LINES: scans one row per clock, starting at row 19.
  - If row[ptr] is all ones (10 bits), rows 0..ptr-1 shift down one row, row 0 becomes 0, and lines_cleared increments (saturating). The pointer does not change, so the same index is re-checked next cycle.
  - Otherwise, if ptr==0, go to GENERATE_PIECE; else ptr decrements.
  - Worst-case duration: 20 + number of full rows cycles. Latency from piece_landed to GENERATE_PIECE with no full rows is 21 clocks (1 to enter CLEAR_LINES, then 20 scan cycles).
  - piece_landed, spawn_* and rotate are ignored here.
  - clearing=1 exactly while in this state.
- GAME_OVER:
  - The board and counter are held.
  - A rising edge of rotate (registered previous-value compare) goes to INITIAL.
  - A level held from before entry does not restart the game.
- Pulses (spawn_*, piece_landed) received outside their owning state are ignored.

Decomposition:
- Shared header tetris_states.vh holds the state codes (INITIAL, GENERATE_PIECE, FALLING, CLEAR_LINES, GAME_OVER), BOARD_W=10, BOARD_H=20 and BOARD_BITS=200.
- One natural sub-module, tetris_line_clear: it holds the row pointer and the shift datapath, and has a start/done handshake with the controller.
- The gravity counter and the state register stay in tetris_game_ctrl.

Test Plan:
- Reset and start: reset, hold rotate for 1 cycle, with the handler model returning GENERATE_PIECE one cycle later -> state 0 -> 1. blocks_exist=0 and lines_cleared=0.
- Gravity: DROP_DIV=8, FAST_DIV=2, in FALLING -> drop_tick every 8th clk. Hold soft_drop -> drop_tick every 2nd clk. piece_landed -> no tick in that cycle.
- Single clear: board_merged has row 19 full and row 18 = bit col0 only -> after the sequence, row 19 = old row 18 and rows 0-18 = 0. lines_cleared=1. GENERATE_PIECE is reached 22 clocks after piece_landed.
- Tetris clear: rows 16-19 full plus a block at row 15 col 3 -> lines_cleared += 4. The block ends at row 19 col 3 and the board is otherwise empty.
- Game over and restart: spawn_blocked and spawn_done pulse in the same cycle -> GAME_OVER. rotate held from before entry -> stay. Release, then press -> INITIAL on the next clk.
- Reset mid-clear: assert rst_n=0 during CLEAR_LINES at ptr=17 -> all outputs return to reset values asynchronously, and state is INITIAL after release.

Source files
------------

// File: rtl/tetris_game_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : tetris_game_ctrl_pkg                                     |
// | Purpose : Shared game-state encoding and board geometry for the    |
// |           Tetris game controller and its line-clear datapath.      |
// | Ports   : none (package)                                           |
// | Rev     : 1.0  initial release                                     |
// +--------------------------------------------------------------------+
package tetris_game_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_INITIAL        = 3'd0,
    ST_GENERATE_PIECE = 3'd1,
    ST_FALLING        = 3'd2,
    ST_CLEAR_LINES    = 3'd3,
    ST_GAME_OVER      = 3'd4
  } state_t;

  localparam int BOARD_W    = 10;
  localparam int BOARD_H    = 20;
  localparam int BOARD_BITS = BOARD_W * BOARD_H;
  localparam int ROW_W      = 5;   // row pointer width, holds 0..19
  localparam int BASE_W     = 8;   // bit offset of a row start, holds 0..190

  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(BOARD_H - 1);

endpackage : tetris_game_ctrl_pkg
`default_nettype wire

// File: rtl/tetris_line_clear.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : tetris_line_clear                                        |
// | Purpose : Row pointer and shift datapath for line clearing. Scans  |
// |           the board bottom-up one row per clock; the controller    |
// |           commits o_board_shifted whenever o_row_full is high.     |
// | Ports   : clk, rst_n        clock / async active-low reset         |
// |           i_start           reload pointer to the bottom row       |
// |           i_active          controller is in CLEAR_LINES           |
// |           i_board           current settled board                  |
// |           o_row_full        row under the pointer is complete      |
// |           o_board_shifted   board with that row removed            |
// |           o_done            scan finished (row 0 checked, not full)|
// | Rev     : 1.0  initial release                                     |
// +--------------------------------------------------------------------+
module tetris_line_clear
  import tetris_game_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_start,
  input  logic                  i_active,
  input  logic [BOARD_BITS-1:0] i_board,
  output logic                  o_row_full,
  output logic [BOARD_BITS-1:0] o_board_shifted,
  output logic                  o_done
);

  logic [ROW_W-1:0]   r_ptr;
  logic [BASE_W-1:0]  w_base;
  logic [BOARD_W-1:0] w_row;
  logic               w_full;

  assign w_base = BASE_W'(r_ptr) * BASE_W'(BOARD_W);
  assign w_row  = i_board[w_base +: BOARD_W];
  assign w_full = i_active & (&w_row);

  assign o_row_full = w_full;
  assign o_done     = i_active & ~w_full & (r_ptr == '0);

  // Rows at or above the pointer take the row above them; rows below the
  // pointer are untouched. Row 0 always becomes empty on a shift.
  for (genvar r = 0; r < BOARD_H; r++) begin : g_row
    if (r == 0) begin : g_top
      assign o_board_shifted[0 +: BOARD_W] = '0;
    end else begin : g_body
      assign o_board_shifted[r*BOARD_W +: BOARD_W] =
        (ROW_W'(r) <= r_ptr) ? i_board[(r-1)*BOARD_W +: BOARD_W]
                             : i_board[r*BOARD_W +: BOARD_W];
    end
  end

  // After a shift the pointer holds so the row that dropped into this
  // index gets checked as well.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= LAST_ROW;
    end else if (i_start) begin
      r_ptr <= LAST_ROW;
    end else if (i_active && !w_full && (r_ptr != '0)) begin
      r_ptr <= r_ptr - 1'b1;
    end
  end

endmodule : tetris_line_clear
`default_nettype wire

// File: rtl/tetris_game_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : tetris_game_ctrl                                         |
// | Purpose : Central Tetris game sequencer. Owns the game state, the  |
// |           settled board, the gravity timer and the cleared-line    |
// |           counter.                                                 |
// | Ports   : clk, rst_n                  clock / async active-low rst |
// |           rotate, soft_drop           player controls (levels)     |
// |           game_next_state_initial,    INITIAL-phase proposals      |
// |           blocks_exist_initial                                     |
// |           spawn_blocked, spawn_done   piece generator results      |
// |           piece_landed, board_merged  piece mover landing report   |
// |           game_current_state          registered state broadcast   |
// |           blocks_exist                settled board (row*10+col)   |
// |           drop_tick                   1-cycle gravity pulse        |
// |           lines_cleared               saturating total             |
// |           clearing                    high in CLEAR_LINES          |
// | Rev     : 1.0  initial release                                     |
// +--------------------------------------------------------------------+
module tetris_game_ctrl
  import tetris_game_ctrl_pkg::*;
#(
  parameter int DROP_DIV = 50_000_000,
  parameter int FAST_DIV = 5_000_000,
  parameter int CNT_W    = 26
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rotate,
  input  logic                  soft_drop,
  input  logic [2:0]            game_next_state_initial,
  input  logic [BOARD_BITS-1:0] blocks_exist_initial,
  input  logic                  spawn_blocked,
  input  logic                  spawn_done,
  input  logic                  piece_landed,
  input  logic [BOARD_BITS-1:0] board_merged,
  output logic [2:0]            game_current_state,
  output logic [BOARD_BITS-1:0] blocks_exist,
  output logic                  drop_tick,
  output logic [15:0]           lines_cleared,
  output logic                  clearing
);

  state_t                r_state;
  state_t                w_next_state;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_tick;
  logic [BOARD_BITS-1:0] r_board;
  logic [15:0]           r_lines;
  logic                  r_rotate_q;

  logic                  w_lc_start;
  logic                  w_lc_active;
  logic                  w_row_full;
  logic                  w_lc_done;
  logic [BOARD_BITS-1:0] w_shifted;
  logic [CNT_W-1:0]      w_div_m1;
  logic                  w_rotate_rise;

  assign w_lc_start    = (r_state == ST_FALLING) && piece_landed;
  assign w_lc_active   = (r_state == ST_CLEAR_LINES);
  assign w_rotate_rise = rotate & ~r_rotate_q;
  assign w_div_m1      = soft_drop ? CNT_W'(FAST_DIV - 1) : CNT_W'(DROP_DIV - 1);

  tetris_line_clear u_line_clear (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_start         (w_lc_start),
    .i_active        (w_lc_active),
    .i_board         (r_board),
    .o_row_full      (w_row_full),
    .o_board_shifted (w_shifted),
    .o_done          (w_lc_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_INITIAL;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_INITIAL: begin
        if (game_next_state_initial == ST_GENERATE_PIECE) begin
          w_next_state = ST_GENERATE_PIECE;
        end
      end
      ST_GENERATE_PIECE: begin
        // A blocked spawn wins over a simultaneous success report.
        if (spawn_blocked) begin
          w_next_state = ST_GAME_OVER;
        end else if (spawn_done) begin
          w_next_state = ST_FALLING;
        end
      end
      ST_FALLING: begin
        if (piece_landed) begin
          w_next_state = ST_CLEAR_LINES;
        end
      end
      ST_CLEAR_LINES: begin
        if (w_lc_done) begin
          w_next_state = ST_GENERATE_PIECE;
        end
      end
      ST_GAME_OVER: begin
        if (w_rotate_rise) begin
          w_next_state = ST_INITIAL;
        end
      end
      default: begin
        w_next_state = ST_INITIAL;
      end
    endcase
  end

  // Counter and tick default to 0 every cycle, so they only move while
  // FALLING and are automatically cleared on entry to it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_tick     <= 1'b0;
      r_board    <= '0;
      r_lines    <= '0;
      r_rotate_q <= 1'b0;
    end else begin
      r_rotate_q <= rotate;
      r_tick     <= 1'b0;
      r_cnt      <= '0;
      case (r_state)
        ST_INITIAL: begin
          r_board <= blocks_exist_initial;
          r_lines <= '0;
        end
        ST_FALLING: begin
          if (piece_landed) begin
            r_board <= board_merged;
          end else if (r_cnt >= w_div_m1) begin
            // >= also covers soft_drop rising with the count already past
            // the fast divisor.
            r_tick <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_CLEAR_LINES: begin
          if (w_row_full) begin
            r_board <= w_shifted;
            if (r_lines != 16'hFFFF) begin
              r_lines <= r_lines + 16'd1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign game_current_state = r_state;
  assign blocks_exist       = r_board;
  assign drop_tick          = r_tick;
  assign lines_cleared      = r_lines;
  assign clearing           = (r_state == ST_CLEAR_LINES);

endmodule : tetris_game_ctrl
`default_nettype wire
